mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with the HI/LO register pair, located in the EX stage beside the ALU.
- Its HI/LO read data feeds the EX result mux, and from there the EX/MEM pipeline register, for mfhi/mflo.
- It models fixed MIPS mult/div latencies and raises a stall request, so the hazard unit can freeze IF/ID/EX while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (must be ≥1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (must be ≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  issue strobe; valid only together with a legal md_op
- md_op  input  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO; MD_NONE is 0
- src_a  input  32  rs operand, already forwarded
- src_b  input  32  rt operand, already forwarded
- flush  input  1  abort the in-flight op (exception/flush from the pipeline)
- busy  output  1  a mult/div operation is in flight
- stall_req  output  1  combinational: busy | (start & md_op is mult/div class)
- hi_out  output  32  current HI register
- lo_out  output  32  current LO register

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, cycle counter=0, pending result=0. It overrides every other input.
- Issue of mult/div, at a clock edge where start=1 and busy=0:
  - Compute the result and latch it into pend_hi/pend_lo.
  - Load the counter with N-1 (N = MULT_CYCLES or DIV_CYCLES) and set busy=1.
- While busy: the counter decrements each edge. On the edge where the counter is 0, HI/LO are loaded from pend_hi/pend_lo and busy clears.
  - Result: busy is high for exactly N cycles.
  - New HI/LO values are visible on hi_out/lo_out the cycle after busy falls.
- Arithmetic:
  - mult: signed 32x32 → 64; HI = [63:32], LO = [31:0].
  - multu: same, with unsigned operands.
  - div: LO = quotient, HI = remainder, truncating toward zero; the remainder takes the sign of the dividend.
  - divu: same, with unsigned operands.
- Divide by zero (src_b==0): the op still takes DIV_CYCLES, then HI/LO are left unchanged.
- Signed overflow (div of 0x80000000 by 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo with start=1 and busy=0: HI (or LO) ← src_a at that edge. No busy, stall_req stays 0.
- start while busy=1: ignored, whatever md_op is. Upstream must not present it; stall_req is already high.
- flush=1 at an edge:
  - Clear busy and the counter; HI/LO keep their current values and the pending result is discarded.
  - A start in the same cycle as flush is also discarded.
  - If flush coincides with the completion edge, the flush wins and HI/LO are not written.
- Illegal or MD_NONE md_op with start=1: no effect.
- stall_req is purely combinational from start/md_op/busy and has no path from hi_out/lo_out. The hazard unit uses it to stall mfhi/mflo/mult/div in ID.

Decomposition:
- The md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) go in the shared constant header next to the existing ALU op and instruction codes.
- The default MULT_CYCLES/DIV_CYCLES values also go in that header.
- One natural sub-module: md_compute, purely combinational. It takes md_op, src_a and src_b and produces res_hi/res_lo plus a div_by_zero flag.
- The top level holds HI/LO, the pending registers, the counter, busy and the flush/start arbitration.

Test Plan:
1. Reset: hold reset=0 with start=1, md_op=MD_MTHI, src_a=0x1234 → hi_out=0, lo_out=0, busy=0. Release reset → all stay 0.
2. mult:
   - Issue MD_MULT with src_a=0xFFFFFFFE (-2), src_b=3 → busy high for exactly 5 cycles, stall_req high from the issue cycle.
   - After busy falls: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA.
   - Repeat with MD_MULTU → hi_out=0x00000002, lo_out=0xFFFFFFFA.
3. div / divu:
   - MD_DIV with src_a=-7 (0xFFFFFFF9), src_b=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - MD_DIVU with 7/2 → LO=3, HI=1.
   - Divide by zero (7/0) → after 10 cycles HI/LO keep their prior values.
4. Move-to and ignored start:
   - MD_MTLO with src_a=0xDEADBEEF → lo_out=0xDEADBEEF next cycle, busy and stall_req never assert.
   - Start MD_MULT, then pulse start with MD_MTHI during busy → HI reflects only the mult result.
5. Flush:
   - Start MD_DIV, assert flush on the 4th busy cycle → busy=0 next edge, HI/LO unchanged.
   - Flush on the completion edge → HI/LO unchanged.
   - A new start afterwards runs normally.
6. Mid-operation reset and back-to-back: reset=0 pulsed asynchronously mid-mult → busy, HI and LO clear immediately. Then:
   - Issue back-to-back MD_MULT ops, the second on the cycle after busy falls.
   - Both complete with the correct values, with no dead cycle required between them.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module  : mult_div_unit_pkg
// Purpose : Shared constants for the EX-stage multiply/divide unit. This file
//           holds the md_op encodings and the default mult/div latencies.
//           It also provides a helper that classifies an op as mult/div class.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for several cycles (and so raise stall_req)
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_md_compute.sv
// ============================================================================
// Module  : mult_div_unit_md_compute
// Purpose : Purely combinational mult/div datapath. It produces the HI/LO
//           result for the selected md_op.
// Ports   : md_op       - operation select
//           src_a/src_b - rs/rt operands
//           res_hi      - remainder (div) or product[63:32] (mult)
//           res_lo      - quotient (div) or product[31:0] (mult)
//           div_by_zero - divide class op with src_b == 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit_md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Operands are extended to 64 bits so the low 64 bits of the product are exact
    assign w_prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // One unsigned divider serves both div and divu.
    // For div, the operands are converted to magnitudes and the signs are restored afterwards.
    // The divisor is forced to 1 on zero so the divider never sees x/0.
    // The result is discarded in that case anyway.
    assign w_signed_div = (md_op == MD_DIV);
    assign w_dvd = (w_signed_div && src_a[31]) ? -src_a : src_a;
    assign w_dvs = (src_b == 32'd0) ? 32'd1 :
                   ((w_signed_div && src_b[31]) ? -src_b : src_b);
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;

    // Truncation toward zero: the quotient sign is the xor of the operand signs.
    // The remainder follows the dividend.
    // 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder.
    assign w_quot = (w_signed_div && (src_a[31] ^ src_b[31])) ? -w_q_mag : w_q_mag;
    assign w_rem  = (w_signed_div && src_a[31]) ? -w_r_mag : w_r_mag;

    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (md_op)
            MD_MULT: begin
                res_hi = w_prod_s[63:32];
                res_lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = w_prod_u[63:32];
                res_lo = w_prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi      = w_rem;
                res_lo      = w_quot;
                div_by_zero = (src_b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module  : mult_div_unit
// Purpose : EX-stage multi-cycle multiply/divide unit with the HI/LO pair.
//           The result is computed at issue and held in pending registers.
//           It is committed to HI/LO after a fixed latency, modelling MIPS
//           mult/div timing.
// Ports   : clk, reset (async, active low)
//           start/md_op/src_a/src_b - issue interface
//           flush                   - abort the in-flight op
//           busy                    - mult/div in flight
//           stall_req               - busy or a mult/div issuing now
//           hi_out/lo_out           - current HI/LO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;
    logic             r_busy;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_by_zero;

    mult_div_unit_md_compute u_md_compute (
        .md_op       (md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .res_hi      (w_res_hi),
        .res_lo      (w_res_lo),
        .div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_count   <= '0;
        end else if (flush) begin
            // Flush beats both a same-cycle start and a completing op
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (r_busy) begin
            // Any start while busy is dropped here
            if (r_count == '0) begin
                r_busy <= 1'b0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end else if (start) begin
            if (is_muldiv(md_op)) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                // A divide by zero still takes the full latency.
                // It then leaves HI/LO untouched.
                r_pend_wr <= !w_div_by_zero;
                r_busy    <= 1'b1;
                r_count   <= is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end else if (md_op == MD_MTHI) begin
                r_hi <= src_a;
            end else if (md_op == MD_MTLO) begin
                r_lo <= src_a;
            end
        end
    end

    assign busy      = r_busy;
    assign stall_req = r_busy | (start & is_muldiv(md_op));
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module  : tb_mult_div_unit
// Purpose : Directed self-checking bench for mult_div_unit. It uses
//           hand-computed expected values.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_busy;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one issue cycle, checking stall_req before the edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        chk("issue_stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        tick();
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Counts busy cycles remaining (bounded), checking stall_req follows busy
    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            chk("busy_stall_req", {31'd0, stall_req}, 32'd1);
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        md_op = MD_MTHI;
        src_a = 32'h1234;
        src_b = 32'd0;
        flush = 1'b0;
        repeat (3) tick();
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        md_op = MD_NONE;
        reset = 1'b1;
        tick();
        chk("post_rst_hi", hi_out, 32'd0);
        chk("post_rst_lo", lo_out, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // mult -2 * 3
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_busy(n_busy);
        chk("mult_cycles", n_busy, 32'd5);
        chk("mult_hi", hi_out, 32'hFFFFFFFF);
        chk("mult_lo", lo_out, 32'hFFFFFFFA);

        // multu 0xFFFFFFFE * 3
        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_busy(n_busy);
        chk("multu_cycles", n_busy, 32'd5);
        chk("multu_hi", hi_out, 32'h00000002);
        chk("multu_lo", lo_out, 32'hFFFFFFFA);

        // div -7 / 2
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_busy(n_busy);
        chk("div_cycles", n_busy, 32'd10);
        chk("div_hi", hi_out, 32'hFFFFFFFF);
        chk("div_lo", lo_out, 32'hFFFFFFFD);

        // divu 7 / 2
        issue(MD_DIVU, 32'd7, 32'd2, 1'b1);
        wait_busy(n_busy);
        chk("divu_hi", hi_out, 32'd1);
        chk("divu_lo", lo_out, 32'd3);

        // divide by zero leaves HI/LO alone
        issue(MD_DIV, 32'd7, 32'd0, 1'b1);
        wait_busy(n_busy);
        chk("dbz_cycles", n_busy, 32'd10);
        chk("dbz_hi", hi_out, 32'd1);
        chk("dbz_lo", lo_out, 32'd3);

        // signed overflow
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_busy(n_busy);
        chk("ovf_hi", hi_out, 32'd0);
        chk("ovf_lo", lo_out, 32'h80000000);

        // mtlo
        issue(MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b0);
        chk("mtlo_lo", lo_out, 32'hDEADBEEF);
        chk("mtlo_hi", hi_out, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_stall", {31'd0, stall_req}, 32'd0);

        // mthi presented while busy is ignored
        issue(MD_MULT, 32'd5, 32'd7, 1'b1);
        start = 1'b1;
        md_op = MD_MTHI;
        src_a = 32'h0000AAAA;
        #1;
        chk("ign_stall", {31'd0, stall_req}, 32'd1);
        tick();
        start = 1'b0;
        md_op = MD_NONE;
        wait_busy(n_busy);
        chk("ign_cycles", n_busy, 32'd4);
        chk("ign_hi", hi_out, 32'd0);
        chk("ign_lo", lo_out, 32'd35);

        // flush on the 4th busy cycle
        issue(MD_DIV, 32'd100, 32'd7, 1'b1);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (12) tick();
        chk("flush_hi", hi_out, 32'd0);
        chk("flush_lo", lo_out, 32'd35);

        // flush on the completion edge
        issue(MD_DIV, 32'd100, 32'd7, 1'b1);
        repeat (9) tick();
        chk("fcomp_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fcomp_busy", {31'd0, busy}, 32'd0);
        chk("fcomp_hi", hi_out, 32'd0);
        chk("fcomp_lo", lo_out, 32'd35);

        // normal op after flush
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
        wait_busy(n_busy);
        chk("after_flush_cycles", n_busy, 32'd10);
        chk("after_flush_hi", hi_out, 32'd2);
        chk("after_flush_lo", lo_out, 32'd14);

        // asynchronous reset mid-mult
        issue(MD_MULT, 32'd6, 32'd7, 1'b1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_hi", hi_out, 32'd0);
        chk("async_rst_lo", lo_out, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // back-to-back mults
        issue(MD_MULT, 32'd6, 32'd7, 1'b1);
        wait_busy(n_busy);
        chk("b2b1_cycles", n_busy, 32'd5);
        chk("b2b1_hi", hi_out, 32'd0);
        chk("b2b1_lo", lo_out, 32'd42);
        issue(MD_MULT, 32'h00010000, 32'h00010000, 1'b1);
        wait_busy(n_busy);
        chk("b2b2_cycles", n_busy, 32'd5);
        chk("b2b2_hi", hi_out, 32'd1);
        chk("b2b2_lo", lo_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
